// File: rtl/instr_sequencer.sv
// Instruction issue controller: fetches program words from a synchronous ROM and
// drives the cpu instruction bus. It holds each word for an opcode-dependent time.
module instr_sequencer #(
  parameter int WIDTH_DATA   = 16,
  parameter int PC_WIDTH     = 8,
  parameter int RS_DEPTH     = 4,
  parameter int HOLD_DEFAULT = 4,
  parameter int HOLD_ALU     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  output logic                  rom_en,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic [WIDTH_DATA-1:0] rom_data,
  output logic [WIDTH_DATA-1:0] instruction,
  output logic                  issue,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [PC_WIDTH-1:0]   pc
);

  localparam int SPW  = $clog2(RS_DEPTH) + 1;
  localparam int HMAX = (HOLD_ALU > HOLD_DEFAULT) ? HOLD_ALU : HOLD_DEFAULT;
  localparam int CW   = $clog2(HMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_HOLD, S_HALTED, S_FAULT
  } state_t;

  state_t              state, state_n;
  logic [SPW-1:0]      sp, sp_m1;
  logic [PC_WIDTH-1:0] rs [RS_DEPTH];
  logic [PC_WIDTH-1:0] next_pc, pc_p1;
  logic [CW-1:0]       cnt;
  logic                single;

  logic [4:0] opcode;
  logic       is_call, is_ret, is_halt, is_alu, rs_full, rs_empty, hold_last;

  assign opcode    = rom_data[WIDTH_DATA-1:WIDTH_DATA-5];
  assign is_call   = (opcode == 5'd20);
  assign is_ret    = (opcode == 5'd21);
  assign is_halt   = (opcode == 5'd31);
  assign is_alu    = (opcode >= 5'd4) && (opcode <= 5'd15);
  assign rs_full   = (sp == SPW'(RS_DEPTH));
  assign rs_empty  = (sp == '0);
  assign sp_m1     = sp - 1'b1;
  assign pc_p1     = pc + 1'b1;
  assign hold_last = (cnt == '0);

  assign rom_en   = (state == S_FETCH);
  assign rom_addr = (state == S_FETCH) ? pc : '0;
  assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_HOLD);
  assign halted   = (state == S_HALTED);
  assign fault    = (state == S_FAULT);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (run || step) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        if (is_halt)                  state_n = S_HALTED;
        else if (is_call && rs_full)  state_n = S_FAULT;
        else if (is_ret && rs_empty)  state_n = S_FAULT;
        else                          state_n = S_HOLD;
      end
      S_HOLD:   if (hold_last) state_n = (run && !single) ? S_FETCH : S_IDLE;
      default:  state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // pc only moves at the end of HOLD; the redirect target waits in next_pc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      next_pc     <= '0;
      sp          <= '0;
      cnt         <= '0;
      instruction <= '0;
      issue       <= 1'b0;
      single      <= 1'b0;
    end else begin
      issue <= 1'b0;
      case (state)
        S_IDLE: single <= !run;
        S_DECODE: if (state_n == S_HOLD) begin
          instruction <= rom_data;
          issue       <= 1'b1;
          cnt         <= is_alu ? CW'(HOLD_ALU - 1) : CW'(HOLD_DEFAULT - 1);
          if (is_call) begin
            sp      <= sp + 1'b1;
            next_pc <= rom_data[PC_WIDTH-1:0];
          end else if (is_ret) begin
            sp      <= sp_m1;
            next_pc <= rs[sp_m1[SPW-2:0]];
          end else begin
            next_pc <= pc_p1;
          end
        end
        S_HOLD: begin
          cnt <= cnt - 1'b1;
          if (hold_last) begin
            pc          <= next_pc;
            instruction <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack storage carries no reset; sp alone defines which entries are live
  always_ff @(posedge clk) begin
    if (state == S_DECODE && is_call && !rs_full)
      rs[sp[SPW-2:0]] <= pc_p1;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural synchronous program ROM.
module tb_instr_sequencer;
  logic        clk = 1'b0, reset = 1'b0, run = 1'b0, step = 1'b0;
  logic        rom_en, issue, busy, halted, fault;
  logic [7:0]  rom_addr, pc;
  logic [15:0] rom_data, instruction;
  logic [15:0] rom [256];
  int checks = 0, failures = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .instruction(instruction), .issue(issue), .busy(busy),
    .halted(halted), .fault(fault), .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF800;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    logic [15:0] ei;
    logic [7:0]  q [$];
    int          n_iss;
    logic [7:0]  last_fetch;

    // 1: straight-line program with ALU hold and HALT
    hold_reset();
    chk("rst_instr", instruction, 0); chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);         chk("rst_rom_en", rom_en, 0);
    chk("rst_halted", halted, 0);     chk("rst_fault", fault, 0);
    chk("rst_issue", issue, 0);       chk("rst_rom_addr", rom_addr, 0);
    rom[0] = 16'h0805; rom[1] = 16'h0802; rom[2] = 16'h2000; rom[3] = 16'hF800;
    run = 1'b1;
    release_reset();
    for (int c = 0; c < 26; c++) begin
      tick();
      if (c >= 2 && c <= 5)        ei = 16'h0805;
      else if (c >= 8 && c <= 11)  ei = 16'h0802;
      else if (c >= 14 && c <= 21) ei = 16'h2000;
      else                         ei = 16'h0000;
      chk($sformatf("t1_instr_c%0d", c), instruction, ei);
      chk($sformatf("t1_issue_c%0d", c), issue, (c == 2 || c == 8 || c == 14));
      if (c == 0) chk("t1_fetch_addr_c0", {rom_en, rom_addr}, 9'h100);
      if (c >= 22) chk($sformatf("t1_halted_c%0d", c), halted, (c >= 24));
    end
    chk("t1_pc_halt", pc, 3);
    chk("t1_busy_halt", busy, 0);

    // 2: CALL / RET redirect
    hold_reset();
    rom[0] = 16'hA005; rom[5] = 16'h0801; rom[6] = 16'hA800; rom[1] = 16'hF800;
    run = 1'b1;
    release_reset();
    q.delete();
    for (int c = 0; c < 200 && !halted; c++) begin
      tick();
      if (rom_en) q.push_back(rom_addr);
    end
    chk("t2_halted", halted, 1);
    chk("t2_nfetch", q.size(), 4);
    while (q.size() < 4) q.push_back(8'hEE);
    chk("t2_fetch0", q[0], 0); chk("t2_fetch1", q[1], 5);
    chk("t2_fetch2", q[2], 6); chk("t2_fetch3", q[3], 1);
    chk("t2_pc", pc, 1);       chk("t2_fault", fault, 0);

    // 3: return-stack overflow on the fifth nested CALL
    hold_reset();
    for (int i = 0; i < 5; i++) rom[i] = 16'hA000 | 16'(i + 1);
    run = 1'b1;
    release_reset();
    n_iss = 0; last_fetch = 8'hEE;
    for (int c = 0; c < 100 && !fault; c++) begin
      tick();
      if (issue) n_iss++;
      if (rom_en) last_fetch = rom_addr;
    end
    chk("t3_fault", fault, 1);     chk("t3_issues", n_iss, 4);
    chk("t3_last_fetch", last_fetch, 4);
    chk("t3_instr", instruction, 0); chk("t3_halted", halted, 0);
    tick(); tick();
    chk("t3_fault_sticky", fault, 1); chk("t3_rom_en", rom_en, 0);

    // 4a: RET with empty stack
    hold_reset();
    rom[0] = 16'hA800;
    run = 1'b1;
    release_reset();
    n_iss = 0;
    for (int c = 0; c < 20 && !fault; c++) begin
      tick();
      if (issue) n_iss++;
    end
    chk("t4_fault", fault, 1); chk("t4_issues", n_iss, 0);
    chk("t4_instr", instruction, 0);

    // 4b: pc wraps from 255 to 0
    hold_reset();
    rom[0] = 16'hA0FF; rom[255] = 16'h0000;
    run = 1'b1;
    release_reset();
    q.delete();
    for (int c = 0; c < 100 && q.size() < 3; c++) begin
      tick();
      if (rom_en) q.push_back(rom_addr);
    end
    chk("t4_nfetch", q.size(), 3);
    while (q.size() < 3) q.push_back(8'hEE);
    chk("t4_wrap0", q[0], 0); chk("t4_wrap1", q[1], 255); chk("t4_wrap2", q[2], 0);

    // 5: single step, second step during HOLD ignored
    hold_reset();
    rom[0] = 16'h0805; rom[1] = 16'h0802;
    release_reset();
    tick(); tick();
    chk("t5_idle_busy", busy, 0);
    n_iss = 0;
    step = 1'b1; tick(); step = 1'b0;
    tick();
    tick(); if (issue) n_iss++;
    step = 1'b1; tick(); step = 1'b0;
    if (issue) n_iss++;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (issue) n_iss++;
    end
    chk("t5_issues", n_iss, 1); chk("t5_busy", busy, 0);
    chk("t5_pc", pc, 1);        chk("t5_instr", instruction, 0);
    chk("t5_halted", halted, 0);

    // 6: asynchronous reset in the middle of ADD's hold
    hold_reset();
    rom[0] = 16'h0805; rom[1] = 16'h2000;
    run = 1'b1;
    release_reset();
    for (int c = 0; c < 10; c++) tick();
    chk("t6_pre_instr", instruction, 16'h2000);
    chk("t6_pre_pc", pc, 1); chk("t6_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_instr", instruction, 0); chk("t6_pc", pc, 0);
    chk("t6_busy", busy, 0);         chk("t6_issue", issue, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction issue controller that feeds the stack CPU's `instruction` input.
- Fetches 16-bit words from a synchronous program ROM and presents each one to the CPU.
- Holds each instruction for an opcode-dependent number of cycles, then returns the bus to NOP.
- Owns the program counter and a return-address stack, so CALL/RET redirect fetch.
- Sits between the program ROM and the cpu instance, replacing hand-timed instruction driving.

Parameters:
WIDTH_DATA, 16, instruction width; opcode = [15:11], operand = [10:0]
PC_WIDTH, 8, program counter / ROM address width
RS_DEPTH, 4, return-stack entries (power of two, ≥2)
HOLD_DEFAULT, 4, hold cycles for non-ALU opcodes
HOLD_ALU, 8, hold cycles for ALU opcodes 4..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level: continuous execution while high
step  input  1  single-cycle pulse: execute one instruction when idle
rom_en  output  1  ROM read enable
rom_addr  output  PC_WIDTH  ROM address (= pc during FETCH)
rom_data  input  WIDTH_DATA  ROM word, valid the cycle after rom_en
instruction  output  WIDTH_DATA  registered instruction to cpu; 0 = NOP
issue  output  1  one-cycle pulse, first cycle a new instruction is driven
busy  output  1  high in FETCH, DECODE, HOLD
halted  output  1  HALT executed
fault  output  1  return-stack overflow/underflow
pc  output  PC_WIDTH  current program counter

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=0, rs pointer=0, instruction=0, rom_en=0, rom_addr=0, issue=0, busy=0, halted=0, fault=0. Reset asserted mid-instruction aborts immediately.
- States: IDLE, FETCH, DECODE, HOLD, HALTED, FAULT.
- IDLE: if run=1 or step=1, go to FETCH. run takes priority; both high means run. Remember whether entry was via step (single mode).
- FETCH (1 cycle): rom_en=1, rom_addr=pc, go to DECODE.
- DECODE (1 cycle): sample rom_data and act on its opcode:
  - opcode 31 (HALT): not issued; instruction stays 0; go to HALTED.
  - opcode 20 (CALL): if stack full, go to FAULT, not issued. Else push pc+1, next_pc=operand[PC_WIDTH-1:0], load instruction.
  - opcode 21 (RET): if stack empty, go to FAULT, not issued. Else pop into next_pc, load instruction.
  - any other opcode: next_pc=pc+1, modulo 2^PC_WIDTH (wraps 255 to 0), load instruction.
  - Hold count N = HOLD_ALU for opcodes 4..15, HOLD_DEFAULT otherwise.
  - Go to HOLD.
- HOLD (exactly N cycles): instruction = fetched word; issue=1 in the first HOLD cycle only. On the last cycle, pc<=next_pc and instruction<=0 at the clock edge. Then:
  - go to FETCH if run=1 and the instruction was not entered via step;
  - otherwise go to IDLE.
- Execution period per issued instruction is N+2 cycles; latency from FETCH to instruction valid is 2 cycles.
- run deasserted mid-instruction: the current instruction completes its full hold, then the block goes to IDLE.
- step while busy: ignored.
- HALTED and FAULT are sticky until reset; rom_en=0 and instruction=0 in both; halted or fault held at 1 respectively.
- CALL and RET are still issued to the cpu, which updates its own state; the sequencer only redirects fetch.
- Return stack: push and pop never occur in the same cycle; depth counts 0..RS_DEPTH.

Test Plan:
- Reset release, run=1. ROM: 0:0x0805 (PUSH_I 5), 1:0x0802 (PUSH_I 2), 2:0x2000 (ADD), 3:0xF800 (HALT). Required: instruction=0x0805 cycles 2-5, 0x0802 cycles 8-11, 0x2000 cycles 14-21. issue pulses at cycles 2, 8, 14. halted=1 from cycle 24 with pc=3.
- CALL/RET: 0:0xA005 (CALL 5), 5:0x0801, 6:0xA800 (RET), 1:HALT. Required: fetch order 0,5,6,1; pc=1 at halt; fault=0.
- Overflow: RS_DEPTH=4 and five nested CALLs to themselves' next address. Required: fault=1 after the fifth DECODE; the fifth CALL is never issued; instruction=0.
- Underflow/wrap: RET at address 0 gives fault=1. Separately, PC_WIDTH=8 with a NOP at 255 gives next fetch address 0.
- Step mode: run=0, step pulsed once. Required: exactly one issue pulse, then IDLE with busy=0. A second step pulsed during HOLD is ignored.
- Async reset asserted mid-HOLD of ADD. Required: instruction=0, pc=0, busy=0 immediately, with no clock edge needed.
